grid_loader: RTL
================

Name: grid_loader

Overview:
- Upstream stage of the grid renderer: fills the 40x30 grid memory before a frame redraw is requested.
- Two modes:
  - copy: stream one level from the level ROM into the grid RAM.
  - fill: write a constant colour to every cell.
- Uses the same start/done pulse handshake as the drawing stages, so the top-level controller can chain it with the renderer.

Parameters:
- GRID_W, 40, cells per row (grid_x counts 0..GRID_W-1).
- GRID_H, 30, rows (grid_y counts 0..GRID_H-1).
- LEVEL_BITS, 2, width of the level select; ROM holds 2^LEVEL_BITS levels.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  request a load; sampled only in IDLE.
- done  out  1  one-cycle pulse when the load completes.
- busy  out  1  high from the cycle after start is accepted until done, inclusive.
- mode  in  1  0 = copy from ROM, 1 = fill; latched at start.
- level  in  LEVEL_BITS  ROM level to copy; latched at start.
- fill_colour  in  3  colour used in fill mode; latched at start.
- rom_addr  out  LEVEL_BITS+11  {level, y[4:0], x[5:0]}.
- rom_data  in  3  ROM output, valid exactly 1 cycle after rom_addr.
- grid_x  out  6  grid RAM write column.
- grid_y  out  5  grid RAM write row.
- grid_in  out  3  grid RAM write data.
- grid_write  out  1  grid RAM write enable.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; counters, pipeline valid, latched mode/level/colour cleared; all outputs 0. A load in progress aborts immediately and grid_write drops without waiting for a clock edge. No done pulse is produced for an aborted load.
- States: IDLE -> INIT -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: when start=1, latch mode, level and fill_colour; go to INIT.
- INIT: clear the x/y issue counters; go to STREAM.
- STREAM:
  - Each cycle, drive rom_addr from the current counters and push (x, y, valid=1) into a 1-deep pipeline register.
  - Counters advance x-first: x wraps 39->0 and increments y.
  - Leave STREAM after issuing (39,29).
- DRAIN: one cycle to retire the last pipeline entry.
- DONE: done=1 for one cycle; go to IDLE.
- Write side:
  - grid_write = pipeline valid.
  - grid_x/grid_y come from the pipeline register.
  - grid_in = rom_data in copy mode, latched fill_colour in fill mode.
  - Fill mode still walks the ROM addresses; rom_data is ignored.
- Timing:
  - Exactly GRID_W*GRID_H = 1200 writes, on consecutive cycles, in raster order.
  - The first write occurs 3 cycles after the start-sampling edge.
  - done is asserted the cycle after the last write.
  - Total start-to-done: 1203 cycles.
- busy is 1 in INIT, STREAM, DRAIN and DONE.
- start while busy is ignored; no queuing.
- Changes to mode, level or fill_colour after start have no effect on the current load.
- Width rules:
  - Counter compares are against GRID_W-1 and GRID_H-1.
  - rom_addr concatenation is zero-extended; no multiply.
- When not writing, grid_x, grid_y and grid_in hold their last values; only grid_write is guaranteed 0.

Decomposition:
- Shared package/header: GRID_W, GRID_H, the coordinate widths (6/5), the colour width (3), and the colour constants (BLACK=3'b000 etc.) used by all drawing stages.
- One natural sub-module, grid_raster_counter: x/y raster counter with clear, increment and at_max outputs. It is reusable by the renderer. The FSM and the write pipeline stay in grid_loader.

Test Plan:
- Reset, then copy level 2 with the ROM model returning (x+y)%8 -> 1200 consecutive writes, first at (0,0) data 0, last at (39,29) data 4; rom_addr of the first issue = 13'h1000; done pulses once, 1203 cycles after start.
- Fill with fill_colour=3'b101, changing fill_colour to 3'b010 mid-load -> all 1200 writes carry 3'b101.
- start held high for 2000 cycles -> exactly one load per IDLE visit; a second load begins only after done; no overlapping writes.
- Assert reset=0 at write 600 (cell (0,15)) -> grid_write, busy and done go to 0 asynchronously. After release, the next start yields a full 1200-write load starting at (0,0).
- Check the row wrap: the write after (39,0) is (0,1); the write after (39,28) is (0,29); no write to x=40 or y=30 ever occurs.
- Pulse start during DONE -> ignored; busy falls the cycle after done; a start in the following IDLE cycle is accepted.

Source files
------------

// File: rtl/grid_loader_pkg.sv
// Shared grid geometry, colour constants and loader state encoding used by
// the grid drawing stages.
package grid_loader_pkg;

  localparam int GRID_W   = 40;
  localparam int GRID_H   = 30;
  localparam int X_W      = 6;
  localparam int Y_W      = 5;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } load_state_e;

endpackage

// File: rtl/grid_loader_raster_counter.sv
// Raster-order x/y cell counter: x advances first, wrapping into y.
module grid_raster_counter
  import grid_loader_pkg::*;
#(
  parameter int W = GRID_W,
  parameter int H = GRID_H
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           inc,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           at_max
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_last;
  logic           y_last;

  assign x_last = (x_q == X_W'(W - 1));
  assign y_last = (y_q == Y_W'(H - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (inc) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign at_max = x_last && y_last;

endmodule

// File: rtl/grid_loader.sv
// Fills the grid RAM from a level ROM (copy) or with one colour (fill),
// using a start/done pulse handshake.
module grid_loader
  import grid_loader_pkg::*;
#(
  parameter int LEVEL_BITS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      done,
  output logic                      busy,
  input  logic                      mode,
  input  logic [LEVEL_BITS-1:0]     level,
  input  logic [COLOUR_W-1:0]       fill_colour,
  output logic [LEVEL_BITS+10:0]    rom_addr,
  input  logic [COLOUR_W-1:0]       rom_data,
  output logic [X_W-1:0]            grid_x,
  output logic [Y_W-1:0]            grid_y,
  output logic [COLOUR_W-1:0]       grid_in,
  output logic                      grid_write
);

  load_state_e             state_q, state_d;
  logic                    mode_q, mode_d;
  logic [LEVEL_BITS-1:0]   level_q, level_d;
  logic [COLOUR_W-1:0]     fill_q, fill_d;
  logic                    pipe_vld_q, pipe_vld_d;
  logic [X_W-1:0]          pipe_x_q, pipe_x_d;
  logic [Y_W-1:0]          pipe_y_q, pipe_y_d;
  logic [COLOUR_W-1:0]     grid_in_q;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [X_W-1:0]          cnt_x;
  logic [Y_W-1:0]          cnt_y;
  logic                    cnt_at_max;

  grid_raster_counter #(
    .W (GRID_W),
    .H (GRID_H)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q == ST_INIT),
    .inc    (state_q == ST_STREAM),
    .x      (cnt_x),
    .y      (cnt_y),
    .at_max (cnt_at_max)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    level_d    = level_q;
    fill_d     = fill_q;
    pipe_vld_d = 1'b0;
    pipe_x_d   = pipe_x_q;
    pipe_y_d   = pipe_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          level_d = level;
          fill_d  = fill_colour;
          state_d = ST_INIT;
        end
      end
      ST_INIT:   state_d = ST_STREAM;
      ST_STREAM: begin
        // The issued cell meets its ROM word one cycle later at the write port.
        pipe_vld_d = 1'b1;
        pipe_x_d   = cnt_x;
        pipe_y_d   = cnt_y;
        if (cnt_at_max) state_d = ST_DRAIN;
      end
      ST_DRAIN:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    grid_in = grid_in_q;
    if (pipe_vld_q) grid_in = mode_q ? fill_q : rom_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      level_q    <= '0;
      fill_q     <= '0;
      pipe_vld_q <= 1'b0;
      pipe_x_q   <= '0;
      pipe_y_q   <= '0;
      grid_in_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      level_q    <= level_d;
      fill_q     <= fill_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_x_q   <= pipe_x_d;
      pipe_y_q   <= pipe_y_d;
      grid_in_q  <= grid_in;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign rom_addr   = {level_q, cnt_y, cnt_x};
  assign grid_write = pipe_vld_q;
  assign grid_x     = pipe_x_q;
  assign grid_y     = pipe_y_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule
